jam_cost_server: RTL and testbench

Responder end of the JAM cost-lookup interface. It holds the 8x8 worker/job cost table and answers the assignment engine's W/J lookups on Cost with a fixed 1-cycle registered latency. It keeps the engine in reset until the table and the expected results are loaded. When the engine raises Valid, it captures MinCost/MatchCount, checks them against the expected values and reports pass/fail and elapsed cycles. It sits between the stimulus loader (testbench or host bus) and the JAM engine.

---
 rtl/jam_cost_server_if.sv | 42 ++++
 rtl/jam_cost_server.sv | 137 +++++++++++++
 tb/tb_jam_cost_server.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_server_if.sv
// Signal bundle between the JAM cost server, its stimulus loader and the JAM engine.
// The master side is the loader plus the engine; the slave side is the server.
interface jam_cost_server_if #(
  parameter int DATA_W = 7,
  parameter int IDX_W  = 3,
  parameter int CYC_W  = 20
);
  // Loader side: table entries and expected results.
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              exp_valid;
  logic [9:0]        exp_min;
  logic [3:0]        exp_cnt;

  // Engine side: reset, cost lookup and results.
  logic              JAM_RST;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [DATA_W-1:0] Cost;
  logic [9:0]        MinCost;
  logic [3:0]        MatchCount;
  logic              Valid;

  // Run status.
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CYC_W-1:0]  cycles;

  modport master (
    output ld_valid, ld_data, exp_valid, exp_min, exp_cnt,
    output W, J, MinCost, MatchCount, Valid,
    input  ld_ready, JAM_RST, Cost, done, pass, timeout, cycles
  );

  modport slave (
    input  ld_valid, ld_data, exp_valid, exp_min, exp_cnt,
    input  W, J, MinCost, MatchCount, Valid,
    output ld_ready, JAM_RST, Cost, done, pass, timeout, cycles
  );
endinterface

// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM assignment engine: loads the 8x8 table and the
// expected result, releases the engine, serves lookups and grades the result.
module jam_cost_server #(
  parameter int               DATA_W  = 7,
  parameter int               IDX_W   = 3,
  parameter int               CYC_W   = 20,
  parameter logic [CYC_W-1:0] TIMEOUT = 20'd1000000
) (
  input  logic           CLK,
  input  logic           RST,
  jam_cost_server_if.slave bus
);

  localparam int               ADDR_W       = 2 * IDX_W;
  localparam int               ENTRIES      = 1 << ADDR_W;
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = TIMEOUT - 1'b1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  // One extra bit so the index can reach ENTRIES, which marks the table as full.
  logic [ADDR_W:0]   load_idx;
  logic              load_full;
  logic              ld_fire;

  logic [DATA_W-1:0] table_mem [ENTRIES];

  logic [9:0]        exp_min_q;
  logic [3:0]        exp_cnt_q;
  logic              exp_loaded;

  logic              jam_rst_q;
  logic [DATA_W-1:0] cost_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [CYC_W-1:0]  cycles_q;

  assign load_full    = load_idx[ADDR_W];
  assign bus.ld_ready = (state == S_LOAD) && !load_full;
  assign ld_fire      = bus.ld_valid && bus.ld_ready;

  assign bus.JAM_RST  = jam_rst_q;
  assign bus.Cost     = cost_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.timeout  = timeout_q;
  assign bus.cycles   = cycles_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:    if (load_full && exp_loaded) state_next = S_RELEASE;
      S_RELEASE: state_next = S_RUN;
      S_RUN:     if (bus.Valid || (cycles_q == TIMEOUT_LAST)) state_next = S_DONE;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_LOAD;
    endcase
  end

  // NOTE: the table has no reset; after reset its contents are undefined and a
  // full reload is required, so clearing it would only cost a reset network.
  always_ff @(posedge CLK) begin
    if (ld_fire) begin
      table_mem[load_idx[ADDR_W-1:0]] <= bus.ld_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_idx   <= '0;
      exp_min_q  <= '0;
      exp_cnt_q  <= '0;
      exp_loaded <= 1'b0;
      jam_rst_q  <= 1'b1;
      cost_q     <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      // Outputs are registered from the next state so they change with the state.
      jam_rst_q <= (state_next != S_RUN);
      done_q    <= (state_next == S_DONE);

      if (ld_fire) begin
        load_idx <= load_idx + 1'b1;
      end

      if ((state == S_LOAD) && bus.exp_valid) begin
        exp_min_q  <= bus.exp_min;
        exp_cnt_q  <= bus.exp_cnt;
        exp_loaded <= 1'b1;
      end

      // The lookup is only served while the engine stays running; Cost is 0 otherwise.
      if ((state == S_RUN) && (state_next == S_RUN)) begin
        cost_q <= table_mem[{bus.W, bus.J}];
      end else begin
        cost_q <= '0;
      end

      if (state == S_RUN) begin
        if (cycles_q != '1) begin
          cycles_q <= cycles_q + 1'b1;
        end
        // Valid takes priority over the timeout in the same cycle.
        if (bus.Valid) begin
          pass_q <= (bus.MinCost == exp_min_q) && (bus.MatchCount == exp_cnt_q);
        end else if (cycles_q == TIMEOUT_LAST) begin
          timeout_q <= 1'b1;
          pass_q    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: two instances share stimulus, one with the
// default timeout for lookups and grading, one with TIMEOUT=50 for the abort path.
module tb_jam_cost_server;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  jam_cost_server_if #(.DATA_W(7), .IDX_W(3), .CYC_W(20)) bus_a ();
  jam_cost_server_if #(.DATA_W(7), .IDX_W(3), .CYC_W(20)) bus_b ();

  assign bus_b.ld_valid   = bus_a.ld_valid;
  assign bus_b.ld_data    = bus_a.ld_data;
  assign bus_b.exp_valid  = bus_a.exp_valid;
  assign bus_b.exp_min    = bus_a.exp_min;
  assign bus_b.exp_cnt    = bus_a.exp_cnt;
  assign bus_b.W          = bus_a.W;
  assign bus_b.J          = bus_a.J;
  assign bus_b.MinCost    = bus_a.MinCost;
  assign bus_b.MatchCount = bus_a.MatchCount;
  assign bus_b.Valid      = bus_a.Valid;

  jam_cost_server dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  jam_cost_server #(.TIMEOUT(20'd50)) dut_to (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst                  = 1'b1;
    bus_a.ld_valid       = 1'b0;
    bus_a.ld_data        = '0;
    bus_a.exp_valid      = 1'b0;
    bus_a.exp_min        = '0;
    bus_a.exp_cnt        = '0;
    bus_a.W              = '0;
    bus_a.J              = '0;
    bus_a.MinCost        = '0;
    bus_a.MatchCount     = '0;
    bus_a.Valid          = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_exp(input int min_v, input int cnt_v);
    bus_a.exp_valid = 1'b1;
    bus_a.exp_min   = 10'(min_v);
    bus_a.exp_cnt   = 4'(cnt_v);
    tick();
    bus_a.exp_valid = 1'b0;
  endtask

  // mode 0: entry k = k, mode 1: 127-k, mode 2: k+1
  task automatic load_table(input int mode, input int first);
    for (int k = first; k < 64; k++) begin
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = (mode == 0) ? 7'(k) : (mode == 1) ? 7'(127 - k) : 7'(k + 1);
      tick();
    end
    bus_a.ld_valid = 1'b0;
  endtask

  // From LOAD with everything loaded: one LOAD->RELEASE edge, one RELEASE->RUN edge.
  task automatic go_run();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (bus_a.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %0b want 1", bus_a.ld_ready); end
    n_checks++; if (bus_a.JAM_RST !== 1'b1) begin n_fail++; $display("FAIL reset_jam_rst got %0b want 1", bus_a.JAM_RST); end
    n_checks++; if (bus_a.Cost !== 7'd0) begin n_fail++; $display("FAIL reset_cost got %0d want 0", bus_a.Cost); end
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus_a.done, bus_a.pass, bus_a.timeout}); end
    n_checks++; if (bus_a.cycles !== 20'd0) begin n_fail++; $display("FAIL reset_cycles got %0d want 0", bus_a.cycles); end
  endtask

  task automatic test_lookup();
    apply_reset();
    send_exp(0, 0);
    load_table(0, 0);
    n_checks++; if (bus_a.ld_ready !== 1'b0) begin n_fail++; $display("FAIL lookup_ready_full got %0b want 0", bus_a.ld_ready); end
    tick();
    n_checks++; if (bus_a.JAM_RST !== 1'b1) begin n_fail++; $display("FAIL lookup_jam_rst_release got %0b want 1", bus_a.JAM_RST); end
    n_checks++; if (bus_a.Cost !== 7'd0) begin n_fail++; $display("FAIL lookup_cost_release got %0d want 0", bus_a.Cost); end
    tick();
    n_checks++; if (bus_a.JAM_RST !== 1'b0) begin n_fail++; $display("FAIL lookup_jam_rst_run got %0b want 0", bus_a.JAM_RST); end
    n_checks++; if (bus_a.cycles !== 20'd0) begin n_fail++; $display("FAIL lookup_cycles_start got %0d want 0", bus_a.cycles); end
    bus_a.W = 3'd3;
    bus_a.J = 3'd5;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd29) begin n_fail++; $display("FAIL lookup_cost_w3j5 got %0d want 29", bus_a.Cost); end
    for (int i = 0; i < 64; i++) begin
      {bus_a.W, bus_a.J} = 6'(i);
      tick();
      n_checks++; if (bus_a.Cost !== 7'(i)) begin n_fail++; $display("FAIL lookup_sweep idx=%0d got %0d want %0d", i, bus_a.Cost, i); end
    end
    n_checks++; if (bus_a.cycles !== 20'd65) begin n_fail++; $display("FAIL lookup_cycles_sweep got %0d want 65", bus_a.cycles); end
    bus_a.Valid = 1'b1;
    tick();
    bus_a.Valid = 1'b0;
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.timeout} !== 3'b110) begin n_fail++; $display("FAIL lookup_result got %b want 110", {bus_a.done, bus_a.pass, bus_a.timeout}); end
    n_checks++; if (bus_a.cycles !== 20'd66) begin n_fail++; $display("FAIL lookup_cycles_done got %0d want 66", bus_a.cycles); end
    n_checks++; if ({bus_a.JAM_RST, bus_a.Cost} !== {1'b1, 7'd0}) begin n_fail++; $display("FAIL lookup_done_outputs got %0b/%0d want 1/0", bus_a.JAM_RST, bus_a.Cost); end
  endtask

  task automatic test_stall_load();
    apply_reset();
    for (int k = 0; k < 63; k++) begin
      bus_a.ld_valid = 1'b1;
      bus_a.ld_data  = 7'(127 - k);
      tick();
      bus_a.ld_valid = 1'b0;
      tick();
    end
    send_exp(0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({bus_a.JAM_RST, bus_a.ld_ready} !== 2'b11) begin n_fail++; $display("FAIL stall_hold_63 cyc=%0d got %b want 11", i, {bus_a.JAM_RST, bus_a.ld_ready}); end
    end
    bus_a.ld_valid = 1'b1;
    bus_a.ld_data  = 7'd64;
    tick();
    bus_a.ld_valid = 1'b0;
    n_checks++; if ({bus_a.JAM_RST, bus_a.ld_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_after_64 got %b want 10", {bus_a.JAM_RST, bus_a.ld_ready}); end
    tick();
    n_checks++; if (bus_a.JAM_RST !== 1'b1) begin n_fail++; $display("FAIL stall_release got %0b want 1", bus_a.JAM_RST); end
    tick();
    n_checks++; if (bus_a.JAM_RST !== 1'b0) begin n_fail++; $display("FAIL stall_run got %0b want 0", bus_a.JAM_RST); end
    bus_a.W = 3'd0; bus_a.J = 3'd0;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd127) begin n_fail++; $display("FAIL stall_cost_00 got %0d want 127", bus_a.Cost); end
    bus_a.W = 3'd7; bus_a.J = 3'd7;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd64) begin n_fail++; $display("FAIL stall_cost_77 got %0d want 64", bus_a.Cost); end
    bus_a.W = 3'd2; bus_a.J = 3'd6;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd105) begin n_fail++; $display("FAIL stall_cost_26 got %0d want 105", bus_a.Cost); end
  endtask

  task automatic test_exp_twice();
    apply_reset();
    send_exp(100, 2);
    // second strobe overlaps the first table entry
    bus_a.exp_valid = 1'b1;
    bus_a.exp_min   = 10'd120;
    bus_a.exp_cnt   = 4'd3;
    bus_a.ld_valid  = 1'b1;
    bus_a.ld_data   = 7'd0;
    tick();
    bus_a.exp_valid = 1'b0;
    load_table(0, 1);
    go_run();
    send_exp(7, 7);
    bus_a.Valid      = 1'b1;
    bus_a.MinCost    = 10'd120;
    bus_a.MatchCount = 4'd3;
    tick();
    bus_a.MinCost = 10'd100;
    bus_a.MatchCount = 4'd2;
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.timeout} !== 3'b110) begin n_fail++; $display("FAIL exp_last_wins got %b want 110", {bus_a.done, bus_a.pass, bus_a.timeout}); end
    tick();
    bus_a.Valid = 1'b0;
    tick();
    n_checks++; if ({bus_a.done, bus_a.pass} !== 2'b11) begin n_fail++; $display("FAIL exp_frozen_pass got %b want 11", {bus_a.done, bus_a.pass}); end
    n_checks++; if (bus_a.cycles !== 20'd2) begin n_fail++; $display("FAIL exp_frozen_cycles got %0d want 2", bus_a.cycles); end

    apply_reset();
    send_exp(100, 2);
    send_exp(120, 3);
    load_table(0, 0);
    go_run();
    bus_a.Valid      = 1'b1;
    bus_a.MinCost    = 10'd100;
    bus_a.MatchCount = 4'd3;
    tick();
    bus_a.Valid = 1'b0;
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.timeout} !== 3'b100) begin n_fail++; $display("FAIL exp_mismatch got %b want 100", {bus_a.done, bus_a.pass, bus_a.timeout}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_exp(5, 1);
    load_table(0, 0);
    go_run();
    repeat (49) tick();
    n_checks++; if ({bus_b.done, bus_b.timeout, bus_b.JAM_RST} !== 3'b000) begin n_fail++; $display("FAIL timeout_before got %b want 000", {bus_b.done, bus_b.timeout, bus_b.JAM_RST}); end
    n_checks++; if (bus_b.cycles !== 20'd49) begin n_fail++; $display("FAIL timeout_cycles_49 got %0d want 49", bus_b.cycles); end
    tick();
    n_checks++; if ({bus_b.done, bus_b.timeout, bus_b.pass, bus_b.JAM_RST} !== 4'b1101) begin n_fail++; $display("FAIL timeout_hit got %b want 1101", {bus_b.done, bus_b.timeout, bus_b.pass, bus_b.JAM_RST}); end
    n_checks++; if (bus_b.cycles !== 20'd50) begin n_fail++; $display("FAIL timeout_cycles_50 got %0d want 50", bus_b.cycles); end
    repeat (3) tick();
    n_checks++; if ({bus_b.cycles, bus_b.timeout} !== {20'd50, 1'b1}) begin n_fail++; $display("FAIL timeout_frozen got %0d/%0b want 50/1", bus_b.cycles, bus_b.timeout); end

    apply_reset();
    send_exp(5, 1);
    load_table(0, 0);
    go_run();
    repeat (49) tick();
    bus_a.Valid      = 1'b1;
    bus_a.MinCost    = 10'd5;
    bus_a.MatchCount = 4'd1;
    tick();
    bus_a.Valid = 1'b0;
    n_checks++; if ({bus_b.done, bus_b.timeout, bus_b.pass} !== 3'b101) begin n_fail++; $display("FAIL timeout_valid_wins got %b want 101", {bus_b.done, bus_b.timeout, bus_b.pass}); end
    n_checks++; if (bus_b.cycles !== 20'd50) begin n_fail++; $display("FAIL timeout_valid_cycles got %0d want 50", bus_b.cycles); end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    send_exp(0, 0);
    load_table(0, 0);
    go_run();
    bus_a.W = 3'd1; bus_a.J = 3'd1;
    repeat (5) tick();
    n_checks++; if (bus_a.cycles !== 20'd5) begin n_fail++; $display("FAIL midrst_cycles_before got %0d want 5", bus_a.cycles); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({bus_a.JAM_RST, bus_a.ld_ready, bus_a.done} !== 3'b110) begin n_fail++; $display("FAIL midrst_async got %b want 110", {bus_a.JAM_RST, bus_a.ld_ready, bus_a.done}); end
    n_checks++; if ({bus_a.cycles, bus_a.Cost} !== {20'd0, 7'd0}) begin n_fail++; $display("FAIL midrst_regs got %0d/%0d want 0/0", bus_a.cycles, bus_a.Cost); end
    tick();
    rst = 1'b0;
    send_exp(0, 0);
    repeat (5) tick();
    n_checks++; if ({bus_a.JAM_RST, bus_a.ld_ready} !== 2'b11) begin n_fail++; $display("FAIL midrst_needs_reload got %b want 11", {bus_a.JAM_RST, bus_a.ld_ready}); end
    load_table(2, 0);
    go_run();
    n_checks++; if (bus_a.JAM_RST !== 1'b0) begin n_fail++; $display("FAIL midrst_rerun got %0b want 0", bus_a.JAM_RST); end
    bus_a.W = 3'd0; bus_a.J = 3'd0;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd1) begin n_fail++; $display("FAIL midrst_cost got %0d want 1", bus_a.Cost); end
  endtask

  task automatic test_ignored_inputs();
    apply_reset();
    load_table(2, 0);
    n_checks++; if ({bus_a.ld_ready, bus_a.JAM_RST} !== 2'b01) begin n_fail++; $display("FAIL ignore_full got %b want 01", {bus_a.ld_ready, bus_a.JAM_RST}); end
    bus_a.ld_valid   = 1'b1;
    bus_a.ld_data    = 7'd99;
    bus_a.Valid      = 1'b1;
    bus_a.MinCost    = 10'd0;
    bus_a.MatchCount = 4'd0;
    repeat (3) tick();
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.JAM_RST} !== 3'b001) begin n_fail++; $display("FAIL ignore_valid_load got %b want 001", {bus_a.done, bus_a.pass, bus_a.JAM_RST}); end
    bus_a.ld_valid = 1'b0;
    bus_a.Valid    = 1'b0;
    send_exp(0, 0);
    go_run();
    bus_a.W = 3'd0; bus_a.J = 3'd0;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd1) begin n_fail++; $display("FAIL ignore_entry0 got %0d want 1", bus_a.Cost); end
    bus_a.W = 3'd7; bus_a.J = 3'd7;
    tick();
    n_checks++; if (bus_a.Cost !== 7'd64) begin n_fail++; $display("FAIL ignore_entry63 got %0d want 64", bus_a.Cost); end
    bus_a.Valid = 1'b1;
    tick();
    bus_a.Valid = 1'b0;
    n_checks++; if ({bus_a.done, bus_a.pass, bus_a.timeout} !== 3'b110) begin n_fail++; $display("FAIL ignore_final got %b want 110", {bus_a.done, bus_a.pass, bus_a.timeout}); end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_lookup();
    test_stall_load();
    test_exp_twice();
    test_timeout();
    test_reset_mid_run();
    test_ignored_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
